// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and constants for the on-chip RAM arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which master owns a command / read return
package onchip_mem_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } arb_state_t;

    typedef logic owner_t;

    localparam owner_t OWNER_M0 = 1'b0;
    localparam owner_t OWNER_M1 = 1'b1;

endpackage

// File: rtl/onchip_mem_rdv_pipe.sv
// Read-return tracking pipeline. Carries {valid, owner} for every issued
// read beat so that the RAM's fixed-latency readdata is routed to the
// master that issued it.
//   clk, reset_n          : clock, async active-low reset (clears all stages)
//   in_valid, in_owner    : read beat issued to the RAM this cycle
//   out_valid, out_owner  : beat whose data is on mem_readdata this cycle
module onchip_mem_rdv_pipe
    import onchip_mem_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner
);

    logic [RD_LATENCY-1:0] vld;
    logic [RD_LATENCY-1:0] own;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            own <= '0;
        end else begin
            vld[0] <= in_valid;
            own[0] <= in_owner;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                own[i] <= own[i-1];
            end
        end
    end

    assign out_valid = vld[RD_LATENCY-1];
    assign out_owner = own[RD_LATENCY-1];

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
// Round-robin arbitration at burst boundaries, internal burst address
// generation, per-master readdatavalid routing.
//   clk, reset_n             : clock, async active-low reset
//   m0_* / m1_*              : Avalon-MM slave ports (m0 = CPU, m1 = DMA)
//   mem_*                    : RAM port (fixed RD_LATENCY read latency)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | arbitrate; grant and issue first beat in the same cycle
// RD_BURST | issue remaining read beats, one per cycle, no master handshake
// WR_BURST | accept remaining write beats whenever the owner asserts write
module onchip_memory_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int BURST_W    = 6,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [BURST_W-1:0]  m0_burstcount,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [BURST_W-1:0]  m1_burstcount,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t           state, state_nxt;
    owner_t               last_grant, last_grant_nxt;
    owner_t               owner, owner_nxt;
    logic [BURST_W-1:0]   beats_left, beats_left_nxt;
    logic [ADDR_W-1:0]    cur_addr, cur_addr_nxt;
    logic [BE_W-1:0]      be_hold, be_hold_nxt;

    logic                 accept;
    owner_t               acc_owner;
    logic                 rd_issue;

    logic                 req0, req1, grant_m1;
    owner_t               grant;
    logic [ADDR_W-1:0]    sel_addr;
    logic [BE_W-1:0]      sel_be;
    logic [DATA_W-1:0]    sel_wd;
    logic [BURST_W-1:0]   sel_bc, sel_beats_left;
    logic                 sel_rd, sel_wr;
    logic                 own_write;

    logic                 rdv_valid;
    logic                 rdv_owner;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    // On a tie the master that did not win last time is chosen.
    assign grant_m1 = req1 & (~req0 | (last_grant == OWNER_M0));
    assign grant    = grant_m1 ? OWNER_M1 : OWNER_M0;

    assign sel_addr = grant_m1 ? m1_address    : m0_address;
    assign sel_be   = grant_m1 ? m1_byteenable : m0_byteenable;
    assign sel_wd   = grant_m1 ? m1_writedata  : m0_writedata;
    assign sel_bc   = grant_m1 ? m1_burstcount : m0_burstcount;
    assign sel_rd   = grant_m1 ? m1_read       : m0_read;
    assign sel_wr   = grant_m1 ? m1_write      : m0_write;

    // burstcount 0 behaves as a single beat.
    assign sel_beats_left = (sel_bc == '0) ? '0 : sel_bc - BURST_W'(1);

    assign own_write = (owner == OWNER_M1) ? m1_write : m0_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= OWNER_M1;
            owner      <= OWNER_M0;
            beats_left <= '0;
            cur_addr   <= '0;
            be_hold    <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            owner      <= owner_nxt;
            beats_left <= beats_left_nxt;
            cur_addr   <= cur_addr_nxt;
            be_hold    <= be_hold_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        beats_left_nxt = beats_left;
        cur_addr_nxt   = cur_addr;
        be_hold_nxt    = be_hold;
        accept         = 1'b0;
        acc_owner      = owner;
        rd_issue       = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = cur_addr;
        mem_byteenable = be_hold;
        mem_writedata  = (owner == OWNER_M1) ? m1_writedata : m0_writedata;

        case (state)
            IDLE: begin
                // reset_n gating keeps waitrequest high and the RAM idle
                // while reset is held, even with requests present.
                if (reset_n && (req0 || req1)) begin
                    accept         = 1'b1;
                    acc_owner      = grant;
                    mem_chipselect = 1'b1;
                    mem_address    = sel_addr;
                    mem_byteenable = sel_be;
                    mem_writedata  = sel_wd;
                    mem_write      = sel_wr & ~sel_rd;
                    rd_issue       = sel_rd;
                    last_grant_nxt = grant;
                    owner_nxt      = grant;
                    be_hold_nxt    = sel_be;
                    cur_addr_nxt   = sel_addr + ADDR_W'(1);
                    beats_left_nxt = sel_beats_left;
                    if (sel_beats_left != '0) begin
                        state_nxt = sel_rd ? RD_BURST : WR_BURST;
                    end
                end
            end

            RD_BURST: begin
                mem_chipselect = 1'b1;
                rd_issue       = 1'b1;
                cur_addr_nxt   = cur_addr + ADDR_W'(1);
                beats_left_nxt = beats_left - BURST_W'(1);
                if (beats_left == BURST_W'(1)) begin
                    state_nxt = IDLE;
                end
            end

            WR_BURST: begin
                if (own_write) begin
                    accept         = 1'b1;
                    mem_chipselect = 1'b1;
                    mem_write      = 1'b1;
                    mem_byteenable = (owner == OWNER_M1) ? m1_byteenable : m0_byteenable;
                    cur_addr_nxt   = cur_addr + ADDR_W'(1);
                    beats_left_nxt = beats_left - BURST_W'(1);
                    if (beats_left == BURST_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign m0_waitrequest = ~(accept && (acc_owner == OWNER_M0));
    assign m1_waitrequest = ~(accept && (acc_owner == OWNER_M1));

    onchip_mem_rdv_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rdv_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_issue),
        .in_owner  (owner_nxt),
        .out_valid (rdv_valid),
        .out_owner (rdv_owner)
    );

    assign m0_readdatavalid = rdv_valid & (rdv_owner == OWNER_M0);
    assign m1_readdatavalid = rdv_valid & (rdv_owner == OWNER_M1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign mem_clken        = 1'b1;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
module tb_onchip_memory_arbiter;

    logic        clk;
    logic        reset_n;

    logic [15:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m1_read, m0_write, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [5:0]  m0_burstcount, m1_burstcount;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;

    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    logic [31:0] ram [65536];

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          checks = 0;
    int          errors = 0;
    int          cnt0 = 0;
    int          cnt1 = 0;
    logic        exp_last;

    onchip_memory_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_burstcount    (m0_burstcount),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_burstcount    (m1_burstcount),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pre(input logic [15:0] a);
        return {~a, a};
    endfunction

    // RAM model: 1-cycle registered read, byte-lane writes.
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: every readdatavalid pops the next expected word for that master.
    initial begin
        forever begin
            @(negedge clk);
            if (m0_readdatavalid) begin
                cnt0++;
                if (q0.size() == 0) check("rdv0_unexpected", 32'd1, 32'd0);
                else                check("rd0_data", m0_readdata, q0.pop_front());
            end
            if (m1_readdatavalid) begin
                cnt1++;
                if (q1.size() == 0) check("rdv1_unexpected", 32'd1, 32'd0);
                else                check("rd1_data", m1_readdata, q1.pop_front());
            end
        end
    end

    task automatic clear_reqs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_burstcount = 6'd1; m1_burstcount = 6'd1;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", {31'd0, n < 50}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        int c0, c1, g, nwr, beat;
        logic [15:0] a0, a1, ea;
        bit wpat [6];

        for (int i = 0; i < 65536; i++) ram[i] = pre(i[15:0]);
        ram[16'h0010] = 32'hDEADBEEF;
        mem_readdata  = '0;
        m0_address = '0; m1_address = '0;
        m0_writedata = '0; m1_writedata = '0;
        clear_reqs();

        // Reset values, with a request present to show reset wins.
        reset_n = 0;
        m0_read = 1;
        #3;
        check("rst_wait0", m0_waitrequest, 1);
        check("rst_wait1", m1_waitrequest, 1);
        check("rst_cs", mem_chipselect, 0);
        check("rst_we", mem_write, 0);
        check("rst_rdv0", m0_readdatavalid, 0);
        check("rst_rdv1", m1_readdatavalid, 0);
        check("rst_clken", mem_clken, 1);
        m0_read = 0;
        repeat (2) @(negedge clk);
        reset_n  = 1;
        exp_last = 1'b1;

        // T1: single read from m0 at 0x0010.
        @(negedge clk);
        m0_address = 16'h0010; m0_read = 1;
        #1;
        check("t1_wait0", m0_waitrequest, 0);
        check("t1_addr", mem_address, 16'h0010);
        check("t1_cs", mem_chipselect, 1);
        q0.push_back(32'hDEADBEEF);
        exp_last = 1'b0;
        @(negedge clk);
        check("t1_rdv0_lat", m0_readdatavalid, 1);
        check("t1_rdv1", m1_readdatavalid, 0);
        m0_read = 0;
        drain();

        // T2: both masters single-read every cycle; grants alternate.
        c0 = cnt0; c1 = cnt1;
        a0 = 16'h1000; a1 = 16'h2000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m0_address = a0; m0_read = 1;
            m1_address = a1; m1_read = 1;
            #1;
            g = (exp_last == 1'b0) ? 1 : 0;
            check("t2_wait0", m0_waitrequest, (g != 0));
            check("t2_wait1", m1_waitrequest, (g != 1));
            check("t2_addr", mem_address, (g == 1) ? a1 : a0);
            if (g == 1) begin q1.push_back(pre(a1)); a1++; end
            else        begin q0.push_back(pre(a0)); a0++; end
            exp_last = g[0];
        end
        @(negedge clk);
        clear_reqs();
        drain();
        check("t2_cnt0", cnt0 - c0, 4);
        check("t2_cnt1", cnt1 - c1, 4);

        // T3: m1 burst of 4 wrapping at 0xFFFF while m0 waits.
        @(negedge clk);
        m1_address = 16'hFFFE; m1_read = 1; m1_burstcount = 6'd4;
        #1;
        check("t3_wait1", m1_waitrequest, 0);
        check("t3_addr0", mem_address, 16'hFFFE);
        ea = 16'hFFFE;
        for (int k = 0; k < 4; k++) begin
            q1.push_back(pre(ea));
            ea++;
        end
        exp_last = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t3_rdv1_consec", m1_readdatavalid, 1);
            m1_read = 0; m1_burstcount = 6'd1;
            m0_address = 16'h0020; m0_read = 1;
            #1;
            ea = 16'hFFFE + 16'(k);
            if (k < 4) begin
                check("t3_wait0_held", m0_waitrequest, 1);
                check("t3_wait1_burst", m1_waitrequest, 1);
                check("t3_addr", mem_address, ea);
                check("t3_cs", mem_chipselect, 1);
            end else begin
                check("t3_m0_grant", m0_waitrequest, 0);
                check("t3_m0_addr", mem_address, 16'h0020);
                q0.push_back(pre(16'h0020));
                exp_last = 1'b0;
            end
        end
        @(negedge clk);
        clear_reqs();
        drain();

        // T4: m0 write burst of 3, byteenable 0x3, with a 2-cycle write gap.
        wpat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        nwr  = 0;
        beat = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            m0_address = 16'h0100; m0_burstcount = 6'd3; m0_byteenable = 4'h3;
            m0_write = wpat[c];
            m0_writedata = {16'hFFFF, 16'h1230 + 16'(beat)};
            if (c >= 1) begin
                m1_address = 16'h0200; m1_read = 1;
            end
            #1;
            if (mem_write) nwr++;
            if (c < 5) begin
                check("t4_wait1_held", m1_waitrequest, 1);
                if (wpat[c]) begin
                    check("t4_wait0", m0_waitrequest, 0);
                    check("t4_we", mem_write, 1);
                    check("t4_addr", mem_address, 16'h0100 + 16'(beat));
                    check("t4_wdata", mem_writedata, {16'hFFFF, 16'h1230 + 16'(beat)});
                    check("t4_be", mem_byteenable, 4'h3);
                    beat++;
                end else begin
                    check("t4_gap_wait0", m0_waitrequest, 1);
                    check("t4_gap_cs", mem_chipselect, 0);
                end
            end else begin
                check("t4_m1_grant", m1_waitrequest, 0);
                check("t4_m1_addr", mem_address, 16'h0200);
                q1.push_back(pre(16'h0200));
                exp_last = 1'b1;
            end
        end
        check("t4_nwrites", nwr, 3);
        @(negedge clk);
        clear_reqs();
        m0_address = 16'h0100; m0_read = 1; m0_burstcount = 6'd3;
        #1;
        check("t4_rb_wait0", m0_waitrequest, 0);
        for (int i = 0; i < 3; i++) begin
            ea = 16'h0100 + 16'(i);
            q0.push_back({~ea, 16'h1230 + 16'(i)});
        end
        exp_last = 1'b0;
        @(negedge clk);
        clear_reqs();
        drain();

        // T5: burstcount 0 from m1 is a single beat.
        c1 = cnt1;
        @(negedge clk);
        m1_address = 16'h0300; m1_read = 1; m1_burstcount = 6'd0;
        #1;
        check("t5_wait1", m1_waitrequest, 0);
        q1.push_back(pre(16'h0300));
        exp_last = 1'b1;
        @(negedge clk);
        m1_read = 0; m1_burstcount = 6'd1;
        m0_address = 16'h0030; m0_read = 1;
        #1;
        check("t5_next_grant", m0_waitrequest, 0);
        q0.push_back(pre(16'h0030));
        exp_last = 1'b0;
        @(negedge clk);
        clear_reqs();
        drain();
        check("t5_cnt1", cnt1 - c1, 1);

        // T6: reset during the 2nd beat of an 8-beat read.
        @(negedge clk);
        m0_address = 16'h0400; m0_read = 1; m0_burstcount = 6'd8;
        #1;
        check("t6_wait0", m0_waitrequest, 0);
        q0.push_back(pre(16'h0400));
        @(negedge clk);
        #2;
        reset_n = 0;
        #1;
        check("t6_rst_wait0", m0_waitrequest, 1);
        check("t6_rst_wait1", m1_waitrequest, 1);
        check("t6_rst_cs", mem_chipselect, 0);
        check("t6_rst_we", mem_write, 0);
        check("t6_rst_rdv0", m0_readdatavalid, 0);
        check("t6_rst_rdv1", m1_readdatavalid, 0);
        clear_reqs();
        repeat (2) @(negedge clk);
        reset_n  = 1;
        exp_last = 1'b1;
        repeat (3) @(negedge clk);
        m0_address = 16'h0010; m0_read = 1;
        #1;
        check("t6_post_wait0", m0_waitrequest, 0);
        check("t6_post_addr", mem_address, 16'h0010);
        q0.push_back(32'hDEADBEEF);
        @(negedge clk);
        clear_reqs();
        drain();

        check("final_q0_empty", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
